tail_light_sequencer: RTL and testbench
=======================================

Name: tail_light_sequencer

Overview:
- Controller that sequences the 6-lamp tail-light FSM (CL[1:0] command in, y[5:0] lamps out).
- Arbitrates three driver requests (left turn, right turn, hazard) into a single CL command.
- Produces a step-enable pulse so the lamp FSM advances at a divided rate.
- Holds each granted command for a full lamp sequence before re-arbitrating; hazard preempts.

Parameters:
- TICK_DIV, 4, clock cycles per lamp step; legal range 1..255.
- MIN_STEPS, 4, lamp steps per sequence; a grant holds at least this long; legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- left_req  in  1  left-turn request, level-sensitive.
- right_req  in  1  right-turn request, level-sensitive.
- hazard_req  in  1  hazard request, level-sensitive.
- CL  out  2  command to lamp FSM: 00 idle, 01 left, 10 right, 11 hazard.
- step_en  out  1  one-cycle pulse: lamp FSM advances one step.
- seq_done  out  1  one-cycle pulse coincident with the last step_en of a sequence.
- busy  out  1  high whenever CL != 00.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, CL=00, step_en=0, seq_done=0, busy=0, div_cnt=0, step_cnt=0. Outputs clear immediately, without waiting for a clock edge. Deassertion takes effect at the next rising edge.
- States: IDLE, LEFT, RIGHT, HAZARD. CL is registered and equals the state encoding. busy = (CL != 00).
- Request decode ("want"), highest priority first:
  - hazard_req=1, or left_req=1 with right_req=1 → HAZARD.
  - else left_req=1 → LEFT.
  - else right_req=1 → RIGHT.
  - else IDLE.
- IDLE: at each edge, go to the want state. Latency is 1 edge from request to CL.
- Entering any non-IDLE state clears div_cnt and step_cnt to 0.
- div_cnt counts 0..TICK_DIV-1 and wraps in non-IDLE states. It is held at 0 in IDLE.
- step_en = (state != IDLE) && (div_cnt == TICK_DIV-1). This is a combinational decode of registers.
- On each step_en, step_cnt increments; it wraps from MIN_STEPS-1 to 0.
- seq_done = step_en && (step_cnt == MIN_STEPS-1).
- LEFT/RIGHT:
  - If want == HAZARD: go to HAZARD at the next edge (preempt) and clear the counters. No seq_done is emitted for the aborted sequence.
  - Otherwise the state holds until the seq_done edge, then moves to want:
    - want == same state: stay; counters wrap to 0 and the sequence restarts.
    - want == other turn: switch directly.
    - want == IDLE: go to IDLE.
  - Requests that change mid-sequence are ignored, except hazard.
- HAZARD: never preempted. At the seq_done edge, move to want; if still HAZARD, restart.
- Simultaneous events:
  - Preempt and seq_done in the same cycle: preempt wins; seq_done is still asserted that cycle.
  - left+right without hazard is treated as hazard.
- TICK_DIV=1: step_en is high every cycle in a non-IDLE state.
- MIN_STEPS=1: every step_en is also seq_done.
- Request glitches shorter than one cycle that miss an edge are ignored. No debounce is performed in this block.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles with all requests at 1 → CL=00, busy=0, step_en=0 throughout. Then reset=1, hazard_req=1 → CL=11 after the first edge.
- Single left sequence: left_req=1 for 1 cycle from IDLE, defaults → CL=01 for exactly 16 cycles. step_en is high on cycles 4, 8, 12, 16 of the state, seq_done only on cycle 16, then CL=00.
- Held turn and direction change: left_req held → CL=01 continuously across the seq_done boundary. Drop left and raise right at cycle 10 → CL stays 01 until cycle 16, then CL=10 with no IDLE cycle in between.
- Hazard preempt: in RIGHT at step_cnt=2, raise hazard_req → CL=11 at the next edge, counters restart, first step_en 4 cycles later. Drop hazard at mid-sequence → HAZARD completes all 16 cycles, then IDLE.
- left+right together from IDLE → CL=11. Drop both → CL returns to 00 only after seq_done.
- Asynchronous reset mid-sequence: in LEFT at cycle 7, pulse reset=0 between clock edges → CL=00 and step_en=0 immediately. After release with no requests, the block stays IDLE.

Source files
------------

// File: rtl/tail_light_sequencer.sv
// Arbitrates left/right/hazard requests into a CL command for the 6-lamp tail-light FSM
// and paces it with a divided step_en pulse; each grant lasts a full lamp sequence.
module tail_light_sequencer #(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned MIN_STEPS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic [1:0] CL,
  output logic       step_en,
  output logic       seq_done,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LEFT   = 2'b01,
    RIGHT  = 2'b10,
    HAZARD = 2'b11
  } state_e;

  localparam logic [7:0] DIV_LAST  = 8'(TICK_DIV - 1);
  localparam logic [7:0] STEP_LAST = 8'(MIN_STEPS - 1);

  state_e     state_q, state_d;
  state_e     want;
  logic [7:0] div_q, div_d;
  logic [7:0] step_q, step_d;
  logic       restart;

  // Both turn signals at once cannot be shown as a turn, so they become hazard.
  always_comb begin
    want = IDLE;
    if (hazard_req || (left_req && right_req)) begin
      want = HAZARD;
    end else if (left_req) begin
      want = LEFT;
    end else if (right_req) begin
      want = RIGHT;
    end
  end

  assign step_en  = (state_q != IDLE) && (div_q == DIV_LAST);
  assign seq_done = step_en && (step_q == STEP_LAST);
  assign CL       = state_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    div_d   = step_en ? 8'd0 : div_q + 8'd1;
    step_d  = step_q;
    if (step_en) begin
      step_d = seq_done ? 8'd0 : step_q + 8'd1;
    end

    unique case (state_q)
      IDLE: begin
        state_d = want;
        restart = 1'b1;
      end
      LEFT, RIGHT: begin
        // Hazard preempts a turn even on the seq_done cycle.
        if (want == HAZARD) begin
          state_d = HAZARD;
          restart = 1'b1;
        end else if (seq_done) begin
          state_d = want;
          restart = 1'b1;
        end
      end
      HAZARD: begin
        if (seq_done) begin
          state_d = want;
          restart = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        restart = 1'b1;
      end
    endcase

    if (restart) begin
      div_d  = 8'd0;
      step_d = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      step_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench for tail_light_sequencer: directed scenarios plus randomized
// requests compared against a sequence-position reference model.
module tb_tail_light_sequencer;

  localparam int TD  = 4;
  localparam int MS  = 4;
  localparam int LEN = TD * MS;

  logic       clk;
  logic       reset;
  logic       left_req;
  logic       right_req;
  logic       hazard_req;
  logic [1:0] CL;
  logic       step_en;
  logic       seq_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model: current mode (0 idle, 1 left, 2 right, 3 hazard) and the
  // number of cycles already spent in the current sequence.
  int m_mode = 0;
  int m_pos  = 0;

  tail_light_sequencer #(.TICK_DIV(TD), .MIN_STEPS(MS)) dut (
    .clk       (clk),
    .reset     (reset),
    .left_req  (left_req),
    .right_req (right_req),
    .hazard_req(hazard_req),
    .CL        (CL),
    .step_en   (step_en),
    .seq_done  (seq_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int want_of(input logic h, input logic l, input logic r);
    if (h || (l && r)) return 3;
    if (l) return 1;
    if (r) return 2;
    return 0;
  endfunction

  function automatic logic [4:0] exp_vec();
    logic [1:0] cl;
    logic       st;
    logic       dn;
    cl = 2'(m_mode);
    st = (m_mode != 0) && ((m_pos % TD) == TD - 1);
    dn = (m_mode != 0) && (m_pos == LEN - 1);
    return {cl, st, dn, m_mode != 0};
  endfunction

  task automatic model_next(input logic h, input logic l, input logic r);
    int w;
    w = want_of(h, l, r);
    if (m_mode == 0) begin
      m_mode = w;
      m_pos  = 0;
    end else if (m_mode != 3 && w == 3) begin
      m_mode = 3;
      m_pos  = 0;
    end else if (m_pos == LEN - 1) begin
      m_mode = w;
      m_pos  = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  // Drive requests, take one rising edge, advance the model, settle 1 time unit.
  task automatic cycle(input logic h, input logic l, input logic r);
    hazard_req = h;
    left_req   = l;
    right_req  = r;
    @(posedge clk);
    if (!reset) begin
      m_mode = 0;
      m_pos  = 0;
    end else begin
      model_next(h, l, r);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && m_mode != 0; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hazard_req = 1'b1;
    left_req   = 1'b1;
    right_req  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({CL, busy, step_en} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_hold: got CL=%b busy=%b step_en=%b want 00/0/0", CL, busy, step_en);
      end
    end
    m_mode = 0;
    m_pos  = 0;
    reset = 1'b1;
    cycle(1'b1, 1'b0, 1'b0);
    total++;
    if (CL !== 2'b11) begin
      bad++;
      $display("[TB] FAIL reset_release_hazard: got CL=%b want 11", CL);
    end
    drain();
  endtask

  task automatic test_single_left();
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= LEN; i++) begin
      total++;
      if ({CL, step_en, seq_done} !== {2'b01, (i % TD) == 0, i == LEN}) begin
        bad++;
        $display("[TB] FAIL single_left c%0d: got CL=%b st=%b dn=%b want 01/%b/%b",
                 i, CL, step_en, seq_done, (i % TD) == 0, i == LEN);
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    total++;
    if (CL !== 2'b00) begin
      bad++;
      $display("[TB] FAIL single_left_end: got CL=%b want 00", CL);
    end
  endtask

  task automatic test_held_turn();
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= LEN; i++) begin
      total++;
      if (CL !== 2'b01) begin
        bad++;
        $display("[TB] FAIL held_left c%0d: got CL=%b want 01", i, CL);
      end
      cycle(1'b0, 1'b1, 1'b0);
    end
    for (int i = 1; i <= LEN; i++) begin
      total++;
      if (CL !== 2'b01) begin
        bad++;
        $display("[TB] FAIL change_dir_hold c%0d: got CL=%b want 01", i, CL);
      end
      if (i < 10) cycle(1'b0, 1'b1, 1'b0);
      else        cycle(1'b0, 1'b0, 1'b1);
    end
    total++;
    if (CL !== 2'b10) begin
      bad++;
      $display("[TB] FAIL change_dir_switch: got CL=%b want 10", CL);
    end
    drain();
  endtask

  task automatic test_hazard_preempt();
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 1'b1);
    total++;
    if (CL !== 2'b10) begin
      bad++;
      $display("[TB] FAIL preempt_pre: got CL=%b want 10", CL);
    end
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= LEN; i++) begin
      total++;
      if ({CL, step_en, seq_done} !== {2'b11, (i % TD) == 0, i == LEN}) begin
        bad++;
        $display("[TB] FAIL preempt_hazard c%0d: got CL=%b st=%b dn=%b want 11/%b/%b",
                 i, CL, step_en, seq_done, (i % TD) == 0, i == LEN);
      end
      if (i < 8) cycle(1'b1, 1'b0, 1'b1);
      else       cycle(1'b0, 1'b0, 1'b0);
    end
    total++;
    if (CL !== 2'b00) begin
      bad++;
      $display("[TB] FAIL preempt_end: got CL=%b want 00", CL);
    end
  endtask

  task automatic test_left_right();
    cycle(1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= LEN; i++) begin
      total++;
      if (CL !== 2'b11) begin
        bad++;
        $display("[TB] FAIL left_right c%0d: got CL=%b want 11", i, CL);
      end
      cycle(1'b0, 1'b0, 1'b0);
    end
    total++;
    if (CL !== 2'b00) begin
      bad++;
      $display("[TB] FAIL left_right_end: got CL=%b want 00", CL);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 2 * TD; i++) cycle(1'b0, 1'b1, 1'b0);
    total++;
    if ({CL, step_en} !== 3'b011) begin
      bad++;
      $display("[TB] FAIL async_pre: got CL=%b st=%b want 01/1", CL, step_en);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({CL, step_en, busy} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL async_clear: got CL=%b st=%b busy=%b want 00/0/0", CL, step_en, busy);
    end
    #1 reset = 1'b1;
    m_mode = 0;
    m_pos  = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      total++;
      if (CL !== 2'b00) begin
        bad++;
        $display("[TB] FAIL async_idle c%0d: got CL=%b want 00", i, CL);
      end
    end
  endtask

  task automatic test_random();
    logic h, l, r;
    logic [4:0] e;
    h = 1'b0;
    l = 1'b0;
    r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        h = ($urandom_range(0, 7) == 0);
        l = ($urandom_range(0, 2) == 0);
        r = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 149) == 0) reset = 1'b0;
      cycle(h, l, r);
      reset = 1'b1;
      e = exp_vec();
      total++;
      if ({CL, step_en, seq_done, busy} !== e) begin
        bad++;
        $display("[TB] FAIL random c%0d: got CL/st/dn/busy=%b want %b", i,
                 {CL, step_en, seq_done, busy}, e);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    hazard_req = 1'b0;
    left_req   = 1'b0;
    right_req  = 1'b0;
    test_reset();
    test_single_left();
    test_held_turn();
    test_hazard_preempt();
    test_left_right();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
